// File: rtl/pio_event_sequencer_pkg.sv
// rtl/pio_event_sequencer_pkg.sv - shared constants and types for the PIO event sequencer
// Purpose : PIO register map, sequencer state encoding and the event word layout.
// Ports   : none (package).
package pio_seq_pkg;

   localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
   localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_CAP  = 2'd3;

   localparam int PIO_DW = 4;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_MASK,
      ST_RD_CAP,
      ST_WAIT_CAP,
      ST_RD_DAT,
      ST_WAIT_DAT
   } seq_state_t;

   // Event word: edges seen by the service, then the input level read right after.
   typedef struct packed {
      logic [PIO_DW-1:0] capture;
      logic [PIO_DW-1:0] level;
   } pio_evt_t;

endpackage

// File: rtl/pio_event_sequencer_if.sv
// rtl/pio_event_sequencer_if.sv - Avalon-MM link between the sequencer and the PIO slave
// Purpose : bundles the PIO register bus and the PIO interrupt.
// Ports   : master drives m_address/m_chipselect/m_write_n/m_writedata and
//           receives m_readdata/pio_irq; slave is the mirror image.
interface pio_event_sequencer_if;

   logic [1:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata;
   logic        pio_irq;

   modport master (
      output m_address, m_chipselect, m_write_n, m_writedata,
      input  m_readdata, pio_irq
   );

   modport slave (
      input  m_address, m_chipselect, m_write_n, m_writedata,
      output m_readdata, pio_irq
   );

endinterface

// File: rtl/pio_event_fifo.sv
// rtl/pio_event_fifo.sv - synchronous show-ahead FIFO for event words
// Purpose : stores event words; head is visible combinationally.
// Ports   : clk, reset_n (async active-low); push/push_data write side;
//           pop/head read side; full, empty, count status.
module pio_event_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: only entries behind a valid pointer are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/pio_event_sequencer.sv
// rtl/pio_event_sequencer.sv - autonomous edge-capture PIO service engine
// Purpose : programs the PIO irq mask, services each PIO irq (read/clear
//           edge_capture, read level) and queues {capture, level} events.
// Ports   : clk, reset_n (async active-low); bus (PIO Avalon-MM master + irq);
//           cfg_mask/cfg_mask_wr mask reprogram request; evt_valid/evt_ready/
//           evt_data event stream; evt_count occupancy; evt_overflow sticky drop flag.
module pio_event_sequencer
   import pio_seq_pkg::*;
#(
   parameter int                    DATA_WIDTH = 4,
   parameter int                    FIFO_DEPTH = 8,
   parameter logic [DATA_WIDTH-1:0] INIT_MASK  = 4'hF
) (
   input  logic                          clk,
   input  logic                          reset_n,
   pio_event_sequencer_if.master         bus,
   input  logic [DATA_WIDTH-1:0]         cfg_mask,
   input  logic                          cfg_mask_wr,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [2*DATA_WIDTH-1:0]       evt_data,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          evt_overflow
);

   seq_state_t            state, next_state;
   logic                  armed;
   logic                  mask_pend;
   logic [DATA_WIDTH-1:0] mask_val;
   logic [DATA_WIDTH-1:0] capture;

   logic                  cs, wr_n;
   logic [1:0]            addr;
   logic [31:0]           wdata;
   logic                  push_req;
   logic                  fifo_full, fifo_empty, fifo_pop, fifo_push, ovf_set;
   logic                  unused_rd;

   assign unused_rd = ^bus.m_readdata[31:DATA_WIDTH];

   assign bus.m_chipselect = cs;
   assign bus.m_write_n    = wr_n;
   assign bus.m_address    = addr;
   assign bus.m_writedata  = wdata;

   assign evt_valid = !fifo_empty;
   assign fifo_pop  = evt_valid && evt_ready;
   assign fifo_push = push_req && (!fifo_full || fifo_pop);
   // Unreachable with this single producer, kept as a guard against lost events.
   assign ovf_set   = push_req && fifo_full && !fifo_pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_INIT;
         armed        <= 1'b0;
         mask_pend    <= 1'b0;
         mask_val     <= '0;
         capture      <= '0;
         evt_overflow <= 1'b0;
      end else begin
         state <= next_state;
         // armed holds the INIT write off the bus while reset is asserted.
         armed <= 1'b1;
         // A new request in the MASK cycle wins over the clear so it is not lost.
         if (cfg_mask_wr) begin
            mask_val  <= cfg_mask;
            mask_pend <= 1'b1;
         end else if (state == ST_MASK) begin
            mask_pend <= 1'b0;
         end
         if (state == ST_WAIT_CAP) capture <= bus.m_readdata[DATA_WIDTH-1:0];
         if (ovf_set) evt_overflow <= 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      cs         = 1'b0;
      wr_n       = 1'b1;
      addr       = PIO_ADDR_DATA;
      wdata      = '0;
      push_req   = 1'b0;
      case (state)
         ST_INIT: begin
            if (armed) begin
               cs         = 1'b1;
               wr_n       = 1'b0;
               addr       = PIO_ADDR_MASK;
               wdata      = 32'(INIT_MASK);
               next_state = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (mask_pend)                   next_state = ST_MASK;
            else if (bus.pio_irq && !fifo_full) next_state = ST_RD_CAP;
         end
         ST_MASK: begin
            cs         = 1'b1;
            wr_n       = 1'b0;
            addr       = PIO_ADDR_MASK;
            wdata      = 32'(mask_val);
            next_state = ST_IDLE;
         end
         ST_RD_CAP: begin
            cs         = 1'b1;
            addr       = PIO_ADDR_CAP;
            next_state = ST_WAIT_CAP;
         end
         ST_WAIT_CAP: begin
            // Clear issued in the same cycle the capture is latched: edges landing
            // in this one cycle can be wiped before they are observed.
            cs         = 1'b1;
            wr_n       = 1'b0;
            addr       = PIO_ADDR_CAP;
            next_state = ST_RD_DAT;
         end
         ST_RD_DAT: begin
            cs         = 1'b1;
            addr       = PIO_ADDR_DATA;
            next_state = ST_WAIT_DAT;
         end
         ST_WAIT_DAT: begin
            // Spurious irq (nothing captured) produces no event.
            push_req   = (capture != '0);
            next_state = ST_IDLE;
         end
         default: next_state = ST_INIT;
      endcase
   end

   pio_event_fifo #(
      .WIDTH (2*DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data ({capture, bus.m_readdata[DATA_WIDTH-1:0]}),
      .pop       (fifo_pop),
      .head      (evt_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (evt_count)
   );

endmodule
